// File: rtl/pea_pkg.sv
// Shared constants and state type for the PEA output-selector configuration path.
package pea_pkg;

  localparam int N_OUT_PEA              = 16;
  localparam int M                      = 12;
  localparam int LOG_M                  = 4;
  localparam int N_CFG_REGS_SEL_OUT_PEA = (N_OUT_PEA * LOG_M + 31) / 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    CHECK = 2'd2
  } state_e;

endpackage : pea_pkg

// File: rtl/cfg_sel_field_check.sv
// Combinational legality check of every selector field in a flattened bank.
// Reports whether all fields are < M and the index of the lowest illegal one.
module cfg_sel_field_check #(
  parameter int N_OUT  = pea_pkg::N_OUT_PEA,
  parameter int M      = pea_pkg::M,
  parameter int LOG_M  = pea_pkg::LOG_M,
  parameter int N_REGS = pea_pkg::N_CFG_REGS_SEL_OUT_PEA,
  parameter int IDX_W  = $clog2(N_OUT)
) (
  input  logic [N_REGS*32-1:0] bank_i,
  output logic                 all_ok_o,
  output logic [IDX_W-1:0]     bad_idx_o
);

  // Scanning from the top down lets the lowest failing field overwrite the index last.
  always_comb begin
    all_ok_o  = 1'b1;
    bad_idx_o = '0;
    for (int j = N_OUT - 1; j >= 0; j--) begin
      if (int'(bank_i[j*LOG_M +: LOG_M]) >= M) begin
        all_ok_o  = 1'b0;
        bad_idx_o = IDX_W'(j);
      end
    end
  end

endmodule : cfg_sel_field_check

// File: rtl/cfg_sel_out_pea_loader.sv
// Streams config words into a shadow bank, validates every selector field,
// and atomically commits the shadow to the active selector bank.
module cfg_sel_out_pea_loader
  import pea_pkg::*;
#(
  parameter int N_OUT  = pea_pkg::N_OUT_PEA,
  parameter int M      = pea_pkg::M,
  parameter int LOG_M  = pea_pkg::LOG_M,
  parameter int N_REGS = pea_pkg::N_CFG_REGS_SEL_OUT_PEA
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       start_i,
  input  logic                       abort_i,
  input  logic [31:0]                cfg_word_i,
  input  logic                       cfg_valid_i,
  output logic                       cfg_ready_o,
  output logic [N_REGS*32-1:0]       reg_cfg_sel_out_pea_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       err_o,
  output logic [$clog2(N_OUT)-1:0]   err_idx_o
);

  localparam int IDX_W = $clog2(N_OUT);
  localparam int CNT_W = (N_REGS > 1) ? $clog2(N_REGS) : 1;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(N_REGS - 1);

  state_e                     state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [N_REGS-1:0][31:0]    shadow_q, shadow_d;
  logic [N_REGS*32-1:0]       active_q, active_d;
  logic                       done_q, done_d;
  logic                       err_q, err_d;
  logic [IDX_W-1:0]           err_idx_q, err_idx_d;

  logic                       all_ok;
  logic [IDX_W-1:0]           bad_idx;

  cfg_sel_field_check #(
    .N_OUT  (N_OUT),
    .M      (M),
    .LOG_M  (LOG_M),
    .N_REGS (N_REGS),
    .IDX_W  (IDX_W)
  ) u_field_check (
    .bank_i    (shadow_q),
    .all_ok_o  (all_ok),
    .bad_idx_o (bad_idx)
  );

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    state_d     = state_q;
    cnt_d       = cnt_q;
    shadow_d    = shadow_q;
    active_d    = active_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    err_idx_d   = err_idx_q;
    cfg_ready_o = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d  = LOAD;
          cnt_d    = '0;
          shadow_d = '0;
        end
      end
      LOAD: begin
        cfg_ready_o = !abort_i;
        if (abort_i) begin
          state_d = IDLE;
        end else if (cfg_valid_i) begin
          shadow_d[cnt_q] = cfg_word_i;
          cnt_d           = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_WORD) state_d = CHECK;
        end
      end
      CHECK: begin
        state_d = IDLE;
        if (!abort_i) begin
          if (all_ok) begin
            active_d = shadow_q;
            done_d   = 1'b1;
          end else begin
            err_d     = 1'b1;
            err_idx_d = bad_idx;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shadow_q  <= '0;
      active_q  <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      err_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      done_q    <= done_d;
      err_q     <= err_d;
      err_idx_q <= err_idx_d;
    end
  end

  assign reg_cfg_sel_out_pea_o = active_q;
  assign busy_o                = (state_q != IDLE);
  assign done_o                = done_q;
  assign err_o                 = err_q;
  assign err_idx_o             = err_idx_q;

endmodule : cfg_sel_out_pea_loader

// File: doc/cfg_sel_out_pea_loader.md
Name: cfg_sel_out_pea_loader

Overview:
- Write side of the PEA output-selector configuration bank.
- Accepts 32-bit configuration words over a valid/ready stream, LSW first, into a shadow bank.
- Checks every LOG_M-bit selector field against M, then atomically commits the shadow bank to the active flattened register vector.
- The active vector feeds the PEA output-selector unpacking logic.

Parameters:
- N_OUT, default N_OUT_PEA (16): number of PEA output selectors.
- M, default 12: number of selectable sources; a legal field value is < M.
- LOG_M, default 4: width of one selector field.
- N_REGS, default N_CFG_REGS_SEL_OUT_PEA = ceil(N_OUT*LOG_M/32) = 2: number of 32-bit config words.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- start_i  in  1  begin a load sequence; honoured only in IDLE.
- abort_i  in  1  cancel an in-progress load.
- cfg_word_i  in  32  configuration word.
- cfg_valid_i  in  1  cfg_word_i is valid.
- cfg_ready_o  out  1  loader accepts a word this cycle.
- reg_cfg_sel_out_pea_o  out  N_REGS*32  active flattened selector bank.
- busy_o  out  1  state != IDLE.
- done_o  out  1  one-cycle pulse: commit succeeded.
- err_o  out  1  one-cycle pulse: illegal field found, no commit.
- err_idx_o  out  $clog2(N_OUT)  index of the lowest illegal field; valid while err_o is high.

Behaviour:
- Reset (synchronous, rst_i high at the clock edge):
  - State goes to IDLE; word counter and shadow bank go to 0.
  - reg_cfg_sel_out_pea_o = 0; done_o = err_o = 0; err_idx_o = 0; busy_o = 0; cfg_ready_o = 0.
  - Reset overrides every other input in the same cycle, and aborts any load in progress.
- Packing:
  - Word k occupies bits [32k+31:32k].
  - Field j occupies bits [(j+1)*LOG_M-1 -: LOG_M].
  - Bits above N_OUT*LOG_M are stored as written and are not checked.
- State machine:
  - IDLE: start_i=1 -> LOAD at the next edge; counter cleared, shadow bank cleared. Otherwise stay in IDLE.
  - LOAD:
    - cfg_ready_o = !abort_i.
    - On a handshake (cfg_valid_i & cfg_ready_o), shadow word[counter] <= cfg_word_i and the counter increments.
    - A handshake with counter == N_REGS-1 moves to CHECK.
    - No handshake: the counter holds. Valid gaps of any length are legal.
  - CHECK (1 cycle):
    - Combinational check of all N_OUT shadow fields.
    - All fields < M: active bank <= shadow at the edge, done_o registered high for the next cycle.
    - Otherwise: active bank unchanged, err_o registered high for the next cycle, err_idx_o = lowest failing field.
    - Goes to IDLE in both cases.
- Latency: last-word handshake in cycle t -> CHECK in cycle t+1 -> new active value, done_o/err_o visible in cycle t+2 (busy_o already 0).
- Abort:
  - abort_i in LOAD or CHECK -> IDLE at the next edge. No commit, no done_o, no err_o; the shadow bank contents are discarded.
  - In the same cycle, abort_i beats a handshake: the word is not accepted.
  - abort_i in IDLE has no effect. abort_i together with start_i in IDLE: start_i wins.
- start_i outside IDLE is ignored. start_i in the pulse cycle after CHECK (state already IDLE) starts a new load normally.
- The active bank changes only in CHECK on success, or on reset.
- cfg_ready_o is 0 in IDLE and CHECK.

Decomposition:
- pea_pkg holds N_OUT_PEA, M, LOG_M, N_CFG_REGS_SEL_OUT_PEA and the state typedef (enum logic [1:0] {IDLE, LOAD, CHECK}).
- Sub-module cfg_sel_field_check: combinational. Takes the flattened shadow bank, returns an all-legal flag plus a priority-encoded lowest illegal index.

Test Plan:
- Nominal load, defaults: start, then words 0x76543210, 0x9A98BA98 -> active = 0x9A98BA98_76543210; done_o high for exactly one cycle, 2 cycles after the last handshake; err_o = 0.
- Illegal field: load 0x0000000C, 0x00000000 -> err_o pulse, err_idx_o = 0, active unchanged (0 after reset), done_o = 0. Repeat with field 9 = 0xF -> err_idx_o = 9.
- Abort: start, accept word 0x11111111, then abort_i with cfg_valid_i high -> word not accepted, busy_o = 0 next cycle, active unchanged, no pulses. A following full load commits correctly.
- Backpressure and gaps: valid toggles 1,0,0,1 -> exactly 2 handshakes, counter holds during gaps, commit as in the nominal case.
- start_i while busy: pulse start_i in LOAD after word 0 -> counter is not reset, load completes with the original word 0.
- Reset mid-load: rst_i after 1 word -> active = 0, cfg_ready_o = 0, state IDLE; no done_o after reset release.
